serial_adder: RTL and testbench

- Bit-serial N-bit adder built on the team's half-adder cell: two half-adder stages plus a registered carry form one full-adder slice.
- Operands are accepted in parallel via a valid/ready handshake and added LSB-first, one bit per clock.
- The result is presented in parallel via a valid/ready handshake.
- Sits in the arithmetic datapath wherever area matters more than latency.

---
 rtl/serial_adder.sv | 154 +++++++++++++++
 tb/tb_serial_adder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice built from two half-adder cells and a carry flop
// processes operands LSB-first, one bit per clock, with valid/ready on both sides.

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one bit of A+B added per cycle, LSB first
// DONE  | result held on Sum/Carry/Overflow until out_ready
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_carry;
  logic             r_ovf;

  logic w_p;
  logic w_g;
  logic w_s;
  logic w_t;
  logic w_c_nxt;
  logic w_accept;
  logic w_last;

  half_adder u_ha0 (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .o_s (w_p),
    .o_c (w_g)
  );

  half_adder u_ha1 (
    .i_a (w_p),
    .i_b (r_c),
    .o_s (w_s),
    .o_c (w_t)
  );

  assign w_c_nxt  = w_g | w_t;
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: in_ready  = 1'b1;
      S_RUN:  busy      = 1'b1;
      S_DONE: out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Sum shifts in at the MSB so bit 0 lands at position 0 after WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_sh <= A;
            r_b_sh <= B;
            r_c    <= Cin;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_sum  <= {w_s, r_sum[WIDTH-1:1]};
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_c    <= w_c_nxt;
          if (w_last) begin
            r_carry <= w_c_nxt;
            r_ovf   <= r_c ^ w_c_nxt;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Sum      = r_sum;
  assign Carry    = r_carry;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder (WIDTH=8) against hand-computed results.

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;
  logic             busy;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Carry     (Carry),
    .Overflow  (Overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand set, returns with the result visible (#1 after the edge that
  // raised out_valid). lat = edges after the accept edge until out_valid was seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int lat);
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1; A = a; B = b; Cin = cin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/busy=%b required 100", {in_ready, out_valid, busy});
    end
    checks++;
    if ({Carry, Overflow, Sum} !== 10'h000) begin
      errors++;
      $display("FAIL reset_data: {C,V,Sum}=%h required 000", {Carry, Overflow, Sum});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    run_op(8'h0F, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== WIDTH) begin
      errors++;
      $display("FAIL basic_latency: edges=%0d required %0d", lat, WIDTH);
    end
    checks++;
    if ({Carry, Overflow, Sum} !== {1'b0, 1'b0, 8'h10}) begin
      errors++;
      $display("FAIL basic_result: C=%0b V=%0b Sum=%h required C=0 V=0 Sum=10", Carry, Overflow, Sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vc [4];
    logic [7:0] es [4];
    logic       ec [4];
    logic       ev [4];
    int lat;
    va = '{8'hFF, 8'h7F, 8'h80, 8'hFF}; vb = '{8'h01, 8'h01, 8'h80, 8'h00};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1};
    es = '{8'h00, 8'h80, 8'h00, 8'h00};
    ec = '{1'b1, 1'b0, 1'b1, 1'b1};
    ev = '{1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], lat);
      checks++;
      if ({Carry, Overflow, Sum} !== {ec[i], ev[i], es[i]}) begin
        errors++;
        $display("FAIL ovf_vec%0d: C=%0b V=%0b Sum=%h required C=%0b V=%0b Sum=%h",
                 i, Carry, Overflow, Sum, ec[i], ev[i], es[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_carry_in();
    int lat;
    out_ready = 1'b1;
    run_op(8'hAA, 8'h55, 1'b1, lat);
    checks++;
    if ({Carry, Overflow, Sum} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL cin_aa55: C=%0b V=%0b Sum=%h required C=1 V=0 Sum=00", Carry, Overflow, Sum);
    end
    @(posedge clk); #1;
    run_op(8'h21, 8'h10, 1'b1, lat);
    checks++;
    if ({Carry, Overflow, Sum} !== {1'b0, 1'b0, 8'h32}) begin
      errors++;
      $display("FAIL cin_2110: C=%0b V=%0b Sum=%h required C=0 V=0 Sum=32", Carry, Overflow, Sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; A = 8'hC3; B = 8'h3C; Cin = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, busy, Carry, Sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h46}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%0b ready=%0b busy=%0b C=%0b Sum=%h required 1 0 0 0 46",
                 i, out_valid, in_ready, busy, Carry, Sum);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: valid/ready=%b required 01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bp_no_capture: busy/valid=%b required 00", {busy, out_valid});
    end
  endtask

  task automatic test_abort();
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; A = 8'hFF; B = 8'hFF; Cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, Sum} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL abort_state: ready/valid/busy=%b Sum=%h required 100 00",
               {in_ready, out_valid, busy}, Sum);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_result: out_valid=%0b required 0", out_valid);
      end
    end
    run_op(8'h03, 8'h04, 1'b0, lat);
    checks++;
    if ({Carry, Overflow, Sum} !== {1'b0, 1'b0, 8'h07}) begin
      errors++;
      $display("FAIL abort_next: C=%0b V=%0b Sum=%h required C=0 V=0 Sum=07", Carry, Overflow, Sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic       cin;
    logic [8:0] ref_full;
    logic       ref_v;
    int         lat, gap, hold, accepted, results;
    accepted = 0; results = 0;
    for (int n = 0; n < 2000; n++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      gap = $urandom_range(0, 3);
      hold = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      out_ready = (hold == 0);
      run_op(a, b, cin, lat);
      accepted++;
      ref_full = {1'b0, a} + {1'b0, b} + {8'h00, cin};
      ref_v = (a[7] == b[7]) && (ref_full[7] != a[7]);
      checks++;
      if ({Carry, Sum, Overflow} !== {ref_full, ref_v} || lat !== WIDTH) begin
        errors++;
        $display("FAIL rand%0d: a=%h b=%h cin=%0b got C=%0b Sum=%h V=%0b lat=%0d required C=%0b Sum=%h V=%0b lat=%0d",
                 n, a, b, cin, Carry, Sum, Overflow, lat, ref_full[8], ref_full[7:0], ref_v, WIDTH);
      end
      if (out_valid) results++;
      repeat (hold) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_dup%0d: out_valid=%0b required 0", n, out_valid);
      end
    end
    checks++;
    if (results !== accepted) begin
      errors++;
      $display("FAIL rand_count: results=%0d required %0d", results, accepted);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_carry_in();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
